// File: rtl/dispatch_alloc_ctrl_pkg.sv
// dispatch_alloc_ctrl_pkg
// Shared types and defaults for the dual-issue dispatch allocation controller.
//   fu_sel_e      : functional-unit select code driven on fu_a / fu_b
//   alloc_state_e : controller FSM state (RUN / STALL / FLUSH)
//   ROB_DEPTH_DEF, FLUSH_CYCLES_DEF : default parameter values
package dispatch_alloc_ctrl_pkg;

    localparam int ROB_DEPTH_DEF    = 16;
    localparam int FLUSH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'b00,
        FU_ALU1 = 2'b01,
        FU_MEM  = 2'b10
    } fu_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } alloc_state_e;

endpackage

// File: rtl/dispatch_alloc_ctrl_fu_rr_assign.sv
// fu_rr_assign
// Combinational functional-unit mapping for one dispatch pair.
//   a_valid, b_valid : slot holds a live instruction (b_valid already qualified by A)
//   a_mem, b_mem     : slot is a memory op
//   rr               : current ALU round-robin bit
//   fu_a, fu_b       : FU select per slot (FU_ALU0 when the slot is not live)
//   rr_toggle        : odd number of ALU ops in the pair; the caller flips rr on fire
module fu_rr_assign
    import dispatch_alloc_ctrl_pkg::*;
(
    input  logic    a_valid,
    input  logic    b_valid,
    input  logic    a_mem,
    input  logic    b_mem,
    input  logic    rr,
    output fu_sel_e fu_a,
    output fu_sel_e fu_b,
    output logic    rr_toggle
);

    logic a_alu;
    logic b_alu;

    assign a_alu = a_valid & ~a_mem;
    assign b_alu = b_valid & ~b_mem;

    always_comb begin
        fu_a = FU_ALU0;
        fu_b = FU_ALU0;
        if (a_valid) begin
            fu_a = a_mem ? FU_MEM : fu_sel_e'({1'b0, rr});
        end
        if (b_valid) begin
            if (b_mem) begin
                fu_b = FU_MEM;
            end else if (a_alu) begin
                // B is the second ALU op in program order
                fu_b = fu_sel_e'({1'b0, ~rr});
            end else begin
                // A went to MEM, so B is the first ALU op
                fu_b = fu_sel_e'({1'b0, rr});
            end
        end
    end

    assign rr_toggle = a_alu ^ b_alu;

endmodule

// File: rtl/dispatch_alloc_ctrl.sv
// dispatch_alloc_ctrl
// Capacity-checked, flush-aware dual-issue dispatch allocator. Hands out
// ROB/RS slot indices for each instruction pair, tracks occupancy against
// retirement, stalls upstream when slots are short and assigns FUs
// (round-robin ALU0/ALU1, fixed MEM).
// Optional build macro: RETIRE_BYPASS_EN -- slots retired this cycle count
// toward this cycle's capacity check (default: one cycle retire-to-reuse).
// Ports:
//   clk, reset       : clock (rising edge), asynchronous active-low reset
//   disp_valid       : slot A valid;  disp_b_valid : slot B valid (needs A)
//   disp_a_mem/b_mem : slot is a memory op
//   retire_cnt       : entries retired this cycle (0..2)
//   flush            : one-cycle pipeline flush pulse
//   alloc_fire       : pair accepted this cycle
//   disp_stall       : upstream must hold its pair
//   rob_idx_a/b      : slot indices (tail, tail+1), zero when disp_valid is low
//   fu_a/fu_b        : FU select (00 ALU0, 01 ALU1, 10 MEM)
//   free_cnt         : free slots from registered occupancy
//   rob_empty        : occupancy is zero
//   stall_cycles     : saturating count of cycles spent in STALL
//   state_dbg        : FSM state for observation
// Handshake: the pair presented with disp_valid is consumed on the rising
// edge of any cycle where alloc_fire is high; otherwise disp_stall is high
// and upstream holds the pair unchanged.
module dispatch_alloc_ctrl
    import dispatch_alloc_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
    parameter int ROB_AW       = $clog2(ROB_DEPTH),
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic              disp_b_valid,
    input  logic              disp_a_mem,
    input  logic              disp_b_mem,
    input  logic [1:0]        retire_cnt,
    input  logic              flush,
    output logic              alloc_fire,
    output logic              disp_stall,
    output logic [ROB_AW-1:0] rob_idx_a,
    output logic [ROB_AW-1:0] rob_idx_b,
    output logic [1:0]        fu_a,
    output logic [1:0]        fu_b,
    output logic [ROB_AW:0]   free_cnt,
    output logic              rob_empty,
    output logic [15:0]       stall_cycles,
    output logic [1:0]        state_dbg
);

    localparam logic [ROB_AW:0] DEPTH_C    = (ROB_AW+1)'(ROB_DEPTH);
    localparam logic [7:0]      FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

    alloc_state_e      state;
    alloc_state_e      state_next;
    logic              in_stall;
    logic              in_flush;

    logic [ROB_AW-1:0] head;
    logic [ROB_AW-1:0] tail;
    logic [ROB_AW:0]   count;
    logic              rr;
    logic [7:0]        flush_cnt;

    logic [ROB_AW-1:0] head_next;
    logic [ROB_AW-1:0] tail_next;
    logic [ROB_AW:0]   count_next;
    logic              rr_next;

    logic              live;
    logic              b_live;
    logic [1:0]        needed;
    logic [ROB_AW+1:0] avail;
    logic              cap_ok;
    logic [ROB_AW+1:0] sum_c;
    logic [ROB_AW+1:0] ret_w;

    fu_sel_e           fu_a_sel;
    fu_sel_e           fu_b_sel;
    logic              rr_toggle;

    // Combinational outputs are quiet while reset is held, whatever upstream drives.
    assign live   = disp_valid & reset;
    assign b_live = live & disp_b_valid;
    assign needed = disp_b_valid ? 2'd2 : 2'd1;

    assign free_cnt  = DEPTH_C - count;
    assign rob_empty = (count == '0);

`ifdef RETIRE_BYPASS_EN
    assign avail = {1'b0, free_cnt} + {{ROB_AW{1'b0}}, retire_cnt};
`else
    assign avail = {1'b0, free_cnt};
`endif

    assign cap_ok     = (avail >= {{ROB_AW{1'b0}}, needed});
    assign alloc_fire = live & ~in_flush & ~flush & cap_ok;
    assign disp_stall = (live & ~alloc_fire) | (reset & in_flush);

    assign rob_idx_a = live ? tail : '0;
    assign rob_idx_b = live ? tail + ROB_AW'(1) : '0;

    fu_rr_assign u_fu (
        .a_valid   (live),
        .b_valid   (b_live),
        .a_mem     (disp_a_mem),
        .b_mem     (disp_b_mem),
        .rr        (rr),
        .fu_a      (fu_a_sel),
        .fu_b      (fu_b_sel),
        .rr_toggle (rr_toggle)
    );

    assign fu_a = fu_a_sel;
    assign fu_b = fu_b_sel;

    // Pointer / occupancy update; flush wins over both allocation and retirement.
    always_comb begin
        sum_c = {1'b0, count} + (alloc_fire ? {{ROB_AW{1'b0}}, needed} : '0);
        ret_w = {{ROB_AW{1'b0}}, retire_cnt};
        // Over-retirement is illegal; clamp so occupancy never wraps negative.
        if (ret_w > sum_c) begin
            count_next = '0;
        end else begin
            count_next = (ROB_AW+1)'(sum_c - ret_w);
        end
        tail_next = tail + (alloc_fire ? ROB_AW'(needed) : '0);
        head_next = head + ROB_AW'(retire_cnt);
        rr_next   = rr ^ (alloc_fire & rr_toggle);
        if (flush) begin
            count_next = '0;
            tail_next  = '0;
            head_next  = '0;
            rr_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= 1'b0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            rr    <= rr_next;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (live && !cap_ok) state_next = ST_STALL;
            ST_STALL: if (alloc_fire) state_next = ST_RUN;
            ST_FLUSH: if (flush_cnt == 8'd0) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
        if (flush) begin
            state_next = ST_FLUSH;
        end
    end

    // FSM: outputs
    always_comb begin
        in_stall  = (state == ST_STALL);
        in_flush  = (state == ST_FLUSH);
        state_dbg = state;
    end

    // Flush hold timer and stall statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt    <= 8'd0;
            stall_cycles <= 16'd0;
        end else begin
            if (flush) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (in_flush && flush_cnt != 8'd0) begin
                flush_cnt <= flush_cnt - 8'd1;
            end
            if (in_stall && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    retire_legal: assert property (@(posedge clk) disable iff (!reset)
        flush || ({{(ROB_AW-1){1'b0}}, retire_cnt} <= count));

    ptr_consistent: assert property (@(posedge clk) disable iff (!reset)
        (tail - head) == count[ROB_AW-1:0]);
`endif

endmodule

// File: tb/tb_dispatch_alloc_ctrl.sv
// tb_dispatch_alloc_ctrl
// Table-driven bench for dispatch_alloc_ctrl (ROB_DEPTH=16, FLUSH_CYCLES=2).
// Each row is one clock cycle: inputs driven at the falling edge, outputs
// compared 1 ns later, state committed at the following rising edge.
module tb_dispatch_alloc_ctrl;

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] STALL = 2'b01;
    localparam logic [1:0] FLUSH = 2'b10;

    typedef struct packed {
        logic       v;
        logic       bv;
        logic       am;
        logic       bm;
        logic [1:0] ret;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic       fire;
        logic       stall;
        logic [3:0] ia;
        logic [3:0] ib;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [4:0] free;
        logic       empty;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    // clock / reset
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        disp_valid;
    logic        disp_b_valid;
    logic        disp_a_mem;
    logic        disp_b_mem;
    logic [1:0]  retire_cnt;
    logic        flush;
    logic        alloc_fire;
    logic        disp_stall;
    logic [3:0]  rob_idx_a;
    logic [3:0]  rob_idx_b;
    logic [1:0]  fu_a;
    logic [1:0]  fu_b;
    logic [4:0]  free_cnt;
    logic        rob_empty;
    logic [15:0] stall_cycles;
    logic [1:0]  state_dbg;

    dispatch_alloc_ctrl #(
        .ROB_DEPTH    (16),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_valid   (disp_valid),
        .disp_b_valid (disp_b_valid),
        .disp_a_mem   (disp_a_mem),
        .disp_b_mem   (disp_b_mem),
        .retire_cnt   (retire_cnt),
        .flush        (flush),
        .alloc_fire   (alloc_fire),
        .disp_stall   (disp_stall),
        .rob_idx_a    (rob_idx_a),
        .rob_idx_b    (rob_idx_b),
        .fu_a         (fu_a),
        .fu_b         (fu_b),
        .free_cnt     (free_cnt),
        .rob_empty    (rob_empty),
        .stall_cycles (stall_cycles),
        .state_dbg    (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[27];

    function automatic vec_t row(
        input logic v, input logic bv, input logic am, input logic bm,
        input logic [1:0] ret, input logic fl,
        input logic fire, input logic stall,
        input logic [3:0] ia, input logic [3:0] ib,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic [4:0] free, input logic empty, input logic [1:0] st);
        vec_t r;
        r.i = '{v: v, bv: bv, am: am, bm: bm, ret: ret, fl: fl};
        r.e = '{fire: fire, stall: stall, ia: ia, ib: ib, fa: fa, fb: fb,
                free: free, empty: empty, st: st};
        return r;
    endfunction

    // driver tasks
    task automatic drive(input in_t i);
        disp_valid   = i.v;
        disp_b_valid = i.bv;
        disp_a_mem   = i.am;
        disp_b_mem   = i.bm;
        retire_cnt   = i.ret;
        flush        = i.fl;
    endtask

    task automatic compare_outputs(input exp_t e, input string name);
        exp_t act;
        act = '{fire: alloc_fire, stall: disp_stall, ia: rob_idx_a, ib: rob_idx_b,
                fa: fu_a, fb: fu_b, free: free_cnt, empty: rob_empty, st: state_dbg};
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got fire=%b stall=%b ia=%0d ib=%0d fa=%b fb=%b free=%0d empty=%b st=%b, want fire=%b stall=%b ia=%0d ib=%0d fa=%b fb=%b free=%0d empty=%b st=%b",
                     name, act.fire, act.stall, act.ia, act.ib, act.fa, act.fb, act.free, act.empty, act.st,
                     e.fire, e.stall, e.ia, e.ib, e.fa, e.fb, e.free, e.empty, e.st);
        end
    endtask

    task automatic apply(input vec_t t, input string name);
        @(negedge clk);
        drive(t.i);
        #1;
        compare_outputs(t.e, name);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    vec_t rst_row;
    vec_t stall_row;
    int   exp_stalls;

    initial begin
        // reset-state expectation: all combinational outputs quiet, ROB empty
        rst_row   = row(0,0,0,0,2'd0,0, 0,0, 4'd0,4'd0, 2'b00,2'b00, 5'd16,1, RUN);
        stall_row = row(1,1,0,0,2'd0,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd0,0, STALL);

        // fill: 8 all-ALU pairs, no retire
        for (int k = 0; k < 8; k++) begin
            tbl[k] = row(1,1,0,0,2'd0,0, 1,0, 4'(2*k),4'(2*k+1), 2'b00,2'b01,
                         5'(16-2*k), (k == 0), RUN);
        end
        // full: ninth pair stalls, then FSM sits in STALL
        tbl[8]  = row(1,1,0,0,2'd0,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd0,0, RUN);
        tbl[9]  = row(1,1,0,0,2'd0,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd0,0, STALL);
`ifdef RETIRE_BYPASS_EN
        tbl[10] = row(1,1,0,0,2'd2,0, 1,0, 4'd0,4'd1, 2'b00,2'b01, 5'd0,0, STALL);
        tbl[11] = row(0,0,0,0,2'd0,0, 0,0, 4'd0,4'd0, 2'b00,2'b00, 5'd0,0, RUN);
        exp_stalls = 3;
`else
        tbl[10] = row(1,1,0,0,2'd2,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd0,0, STALL);
        tbl[11] = row(1,1,0,0,2'd0,0, 1,0, 4'd0,4'd1, 2'b00,2'b01, 5'd2,0, STALL);
        exp_stalls = 4;
`endif
        // flush with a valid pair and a retire in the same cycle, then 2 held cycles
        tbl[12] = row(1,1,0,0,2'd2,1, 0,1, 4'd2,4'd3, 2'b00,2'b01, 5'd0,0, RUN);
        tbl[13] = row(1,1,0,0,2'd0,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd16,1, FLUSH);
        tbl[14] = row(1,1,0,0,2'd0,0, 0,1, 4'd0,4'd1, 2'b00,2'b01, 5'd16,1, FLUSH);
        tbl[15] = row(1,1,0,0,2'd0,0, 1,0, 4'd0,4'd1, 2'b00,2'b01, 5'd16,1, RUN);
        // FU mapping: single ALU (rr 0->1), mem/ALU (rr 1->0), mem/mem, ALU/mem (0->1)
        tbl[16] = row(1,0,0,0,2'd0,0, 1,0, 4'd2,4'd3,   2'b00,2'b00, 5'd14,0, RUN);
        tbl[17] = row(1,1,1,0,2'd0,0, 1,0, 4'd3,4'd4,   2'b10,2'b01, 5'd13,0, RUN);
        tbl[18] = row(1,1,1,1,2'd0,0, 1,0, 4'd5,4'd6,   2'b10,2'b10, 5'd11,0, RUN);
        tbl[19] = row(1,1,0,1,2'd0,0, 1,0, 4'd7,4'd8,   2'b00,2'b10, 5'd9,0,  RUN);
        tbl[20] = row(1,1,0,0,2'd0,0, 1,0, 4'd9,4'd10,  2'b01,2'b00, 5'd7,0,  RUN);
        tbl[21] = row(1,1,0,0,2'd0,0, 1,0, 4'd11,4'd12, 2'b01,2'b00, 5'd5,0,  RUN);
        tbl[22] = row(1,0,0,0,2'd0,0, 1,0, 4'd13,4'd14, 2'b01,2'b00, 5'd3,0,  RUN);
        tbl[23] = row(1,0,0,0,2'd0,0, 1,0, 4'd14,4'd15, 2'b00,2'b00, 5'd2,0,  RUN);
        // one free slot: pair stalls, single mem op fires at 15 and wraps tail
        tbl[24] = row(1,1,0,0,2'd0,0, 0,1, 4'd15,4'd0,  2'b01,2'b00, 5'd1,0,  RUN);
        tbl[25] = row(1,0,1,0,2'd0,0, 1,0, 4'd15,4'd0,  2'b10,2'b00, 5'd1,0,  STALL);
        // rr still 1 after the mem op, tail now 0
        tbl[26] = row(1,0,0,0,2'd0,0, 0,1, 4'd0,4'd1,   2'b01,2'b00, 5'd0,0,  RUN);

        reset = 1'b0;
        drive(rst_row.i);
        apply(rst_row, "reset_state");
        check("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 27; k++) begin
            apply(tbl[k], $sformatf("vec%0d", k));
        end

        @(negedge clk);
        drive(rst_row.i);
        #1;
        check("stall_cycles_after_table", 32'(stall_cycles), 32'(exp_stalls));

        // async reset while stalled
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 9; k++) begin
            apply(tbl[k], $sformatf("refill%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            apply(stall_row, $sformatf("hold_stall%0d", k));
        end
        @(negedge clk);
        #1;
        check("stall_cycles_before_reset", 32'(stall_cycles), 32'd5);
        check("state_before_reset", 32'(state_dbg), 32'(STALL));
        #1;
        reset = 1'b0;
        #1;
        compare_outputs(rst_row.e, "async_reset_outputs");
        check("async_reset_stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        drive(rst_row.i);
        reset = 1'b1;
        apply(tbl[0], "post_reset_pair");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
